// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and produces the 4-bit aluOp class consumed by the ALU-control decoder.
module mc_control_unit #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       mem_ready,
   input  logic       alu_zero,
   input  logic       alu_neg,
   output logic [3:0] aluOp,
   output logic       ir_write,
   output logic       pc_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_byte,
   output logic       i_or_d,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       pc_source,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   localparam logic [5:0] OP_RTYPE    = 6'b000000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SW       = 6'b101011;
   localparam logic [5:0] OP_LBU      = 6'b100100;
   localparam logic [5:0] OP_SB       = 6'b101000;
   localparam logic [5:0] OP_ADDIU    = 6'b001001;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_BLEZ     = 6'b000110;
   localparam logic [5:0] OP_BGTZ     = 6'b000111;

   localparam logic [3:0] ALU_RTYPE  = 4'b0000;
   localparam logic [3:0] ALU_CLZ    = 4'b0001;
   localparam logic [3:0] ALU_ADD    = 4'b0010;
   localparam logic [3:0] ALU_BEQ    = 4'b0011;
   localparam logic [3:0] ALU_ADDIU  = 4'b0100;
   localparam logic [3:0] ALU_LBU    = 4'b0101;
   localparam logic [3:0] ALU_BGTZ   = 4'b0110;
   localparam logic [3:0] ALU_SB     = 4'b0111;
   localparam logic [3:0] ALU_B      = 4'b1000;
   localparam logic [3:0] ALU_BLEZ   = 4'b1001;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
      EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, TRAP
   } state_t;

   state_t           state, nextState;
   logic [CNT_W-1:0] waitCnt;
   logic             illegalReg;

   logic isLoad, isStore, isRType, isSpecial2, isAddiu;
   logic isBeq, isB, isBlez, isBgtz, isBranch;
   logic waiting, timeout;

   // Instruction classification; only meaningful once the IR has been loaded.
   always_comb begin
      isLoad     = (opcode == OP_LW) || (opcode == OP_LBU);
      isStore    = (opcode == OP_SW) || (opcode == OP_SB);
      isRType    = (opcode == OP_RTYPE);
      isSpecial2 = (opcode == OP_SPECIAL2);
      isAddiu    = (opcode == OP_ADDIU);
      isBeq      = (opcode == OP_BEQ);
      isB        = isBeq && (rs == 5'd0) && (rt == 5'd0);
      isBlez     = (opcode == OP_BLEZ);
      isBgtz     = (opcode == OP_BGTZ);
      isBranch   = isBeq || isBlez || isBgtz;
   end

   assign waiting = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) && !mem_ready;
   assign timeout = waiting && (waitCnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         waitCnt    <= '0;
         illegalReg <= 1'b0;
      end else begin
         state <= nextState;
         if (nextState != state)
            waitCnt <= '0;
         else if (waiting)
            waitCnt <= waitCnt + CNT_W'(1);
         if (nextState == TRAP)
            illegalReg <= 1'b1;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:     nextState = FETCH;
         FETCH: begin
            if (mem_ready)    nextState = DECODE;
            else if (timeout) nextState = TRAP;
         end
         DECODE: begin
            if (isLoad || isStore)         nextState = MEM_ADDR;
            else if (isRType || isSpecial2) nextState = EXEC_R;
            else if (isAddiu)              nextState = EXEC_I;
            else if (isBranch)             nextState = BRANCH;
            else                           nextState = TRAP;
         end
         MEM_ADDR: nextState = isLoad ? MEM_RD : MEM_WR;
         MEM_RD: begin
            if (mem_ready)    nextState = MEM_WB;
            else if (timeout) nextState = TRAP;
         end
         MEM_WB:   nextState = FETCH;
         MEM_WR: begin
            if (mem_ready)    nextState = FETCH;
            else if (timeout) nextState = TRAP;
         end
         EXEC_R:   nextState = R_WB;
         R_WB:     nextState = FETCH;
         EXEC_I:   nextState = I_WB;
         I_WB:     nextState = FETCH;
         BRANCH:   nextState = FETCH;
         TRAP:     nextState = TRAP;
         default:  nextState = TRAP;
      endcase
   end

   // NOTE: every output gets a default before the case so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      aluOp      = ALU_RTYPE;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_byte   = 1'b0;
      i_or_d     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      pc_source  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      unique case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            aluOp     = ALU_ADD;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            alu_src_b = SRCB_BR;
            aluOp     = ALU_ADD;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            if (opcode == OP_LBU)     aluOp = ALU_LBU;
            else if (opcode == OP_SB) aluOp = ALU_SB;
            else                      aluOp = ALU_ADD;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            mem_byte = (opcode == OP_LBU);
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            mem_byte  = (opcode == OP_SB);
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            aluOp     = isSpecial2 ? ALU_CLZ : ALU_RTYPE;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            aluOp     = ALU_ADDIU;
         end
         I_WB: reg_write = 1'b1;
         BRANCH: begin
            alu_src_a = 1'b1;
            pc_source = 1'b1;
            // Branch resolution uses the live ALU flags from regA vs regB.
            if (isB) begin
               aluOp    = ALU_B;
               pc_write = 1'b1;
            end else if (isBeq) begin
               aluOp    = ALU_BEQ;
               pc_write = alu_zero;
            end else if (isBgtz) begin
               aluOp    = ALU_BGTZ;
               pc_write = !alu_zero && !alu_neg;
            end else begin
               aluOp    = ALU_BLEZ;
               pc_write = alu_zero || alu_neg;
            end
         end
         default: ;
      endcase
   end

   assign illegal = illegalReg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class cycle by cycle
// and compares the packed control word against hand-derived values.
module tb_mc_control_unit;

   logic       clk, reset;
   logic [5:0] opcode;
   logic [4:0] rs, rt;
   logic       mem_ready, alu_zero, alu_neg;
   logic [3:0] aluOp;
   logic       ir_write, pc_write, mem_read, mem_write, mem_byte, i_or_d;
   logic       alu_src_a, pc_source, reg_write, reg_dst, mem_to_reg, illegal;
   logic [1:0] alu_src_b;

   int nChecks = 0;
   int nFail   = 0;

   mc_control_unit #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .rs(rs), .rt(rt),
      .mem_ready(mem_ready), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .aluOp(aluOp), .ir_write(ir_write), .pc_write(pc_write),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte),
      .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed control word: {aluOp, 14 flag bits}
   logic [17:0] obs;
   assign obs = {aluOp, ir_write, pc_write, mem_read, mem_write, mem_byte, i_or_d,
                 alu_src_a, alu_src_b, pc_source, reg_write, reg_dst, mem_to_reg, illegal};

   localparam logic [13:0] IRW = 14'd1 << 13;
   localparam logic [13:0] PCW = 14'd1 << 12;
   localparam logic [13:0] MRD = 14'd1 << 11;
   localparam logic [13:0] MWR = 14'd1 << 10;
   localparam logic [13:0] MB  = 14'd1 << 9;
   localparam logic [13:0] IOD = 14'd1 << 8;
   localparam logic [13:0] SA  = 14'd1 << 7;
   localparam logic [13:0] SB1 = 14'd1 << 6;
   localparam logic [13:0] SB0 = 14'd1 << 5;
   localparam logic [13:0] PCS = 14'd1 << 4;
   localparam logic [13:0] RW  = 14'd1 << 3;
   localparam logic [13:0] RD  = 14'd1 << 2;
   localparam logic [13:0] M2R = 14'd1 << 1;
   localparam logic [13:0] ILL = 14'd1;

   localparam logic [17:0] IDLE_W    = 18'd0;
   localparam logic [17:0] FETCH_W   = {4'b0010, MRD | SB0};
   localparam logic [17:0] FETCH_R   = {4'b0010, IRW | PCW | MRD | SB0};
   localparam logic [17:0] DECODE_W  = {4'b0010, SB1 | SB0};
   localparam logic [17:0] TRAP_W    = {4'b0000, ILL};

   task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then check the outputs.
   task automatic cyc(input logic rdy, input logic z, input logic n,
                      input string tag, input logic [17:0] exp);
      @(negedge clk);
      mem_ready = rdy;
      alu_zero  = z;
      alu_neg   = n;
      #1;
      check(tag, obs, exp);
   endtask

   task automatic applyReset(input string tag);
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1;
      check(tag, obs, IDLE_W);
      @(negedge clk);
      @(negedge clk);
      check({tag, "_held"}, obs, IDLE_W);
      reset     = 1'b0;
      mem_ready = 1'b0;
      #1;
      check({tag, "_idle"}, obs, IDLE_W);
   endtask

   task automatic fetchDecode(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                              input string tag);
      opcode = op;
      rs     = s;
      rt     = t;
      cyc(1'b1, 1'b0, 1'b0, {tag, "_fetch"}, FETCH_R);
      cyc(1'b0, 1'b0, 1'b0, {tag, "_decode"}, DECODE_W);
   endtask

   initial begin
      reset = 1'b1; opcode = 6'b0; rs = 5'd0; rt = 5'd0;
      mem_ready = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
      applyReset("por");

      // ADD: FETCH, DECODE, EXEC_R, R_WB
      fetchDecode(6'b000000, 5'd3, 5'd4, "add");
      cyc(1'b0, 1'b0, 1'b0, "add_exec", {4'b0000, SA});
      cyc(1'b0, 1'b0, 1'b0, "add_wb",   {4'b0000, RW | RD});

      // LBU with three wait cycles in MEM_RD
      fetchDecode(6'b100100, 5'd5, 5'd6, "lbu");
      cyc(1'b0, 1'b0, 1'b0, "lbu_addr", {4'b0101, SA | SB1});
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b0, 1'b0, "lbu_rd_wait", {4'b0000, MRD | MB | IOD});
      cyc(1'b1, 1'b0, 1'b0, "lbu_rd_done", {4'b0000, MRD | MB | IOD});
      cyc(1'b0, 1'b0, 1'b0, "lbu_wb",      {4'b0000, RW | M2R});

      // SW with a fetch wait, then reset mid-MEM_WR
      opcode = 6'b101011;
      cyc(1'b0, 1'b0, 1'b0, "sw_fetch_wait", FETCH_W);
      cyc(1'b1, 1'b0, 1'b0, "sw_fetch", FETCH_R);
      cyc(1'b0, 1'b0, 1'b0, "sw_decode", DECODE_W);
      cyc(1'b0, 1'b0, 1'b0, "sw_addr", {4'b0010, SA | SB1});
      cyc(1'b0, 1'b0, 1'b0, "sw_wr_wait", {4'b0000, MWR | IOD});
      applyReset("rst_mid_wr");

      // CLZ after reset; first FETCH must show no write request
      opcode = 6'b011100;
      cyc(1'b0, 1'b0, 1'b0, "post_rst_fetch", FETCH_W);
      cyc(1'b1, 1'b0, 1'b0, "clz_fetch", FETCH_R);
      cyc(1'b0, 1'b0, 1'b0, "clz_decode", DECODE_W);
      cyc(1'b0, 1'b0, 1'b0, "clz_exec", {4'b0001, SA});
      cyc(1'b0, 1'b0, 1'b0, "clz_wb",   {4'b0000, RW | RD});

      // ADDIU
      fetchDecode(6'b001001, 5'd1, 5'd2, "addiu");
      cyc(1'b0, 1'b0, 1'b0, "addiu_exec", {4'b0100, SA | SB1});
      cyc(1'b0, 1'b0, 1'b0, "addiu_wb",   {4'b0000, RW});

      // SB completing immediately
      fetchDecode(6'b101000, 5'd7, 5'd8, "sb");
      cyc(1'b0, 1'b0, 1'b0, "sb_addr", {4'b0111, SA | SB1});
      cyc(1'b1, 1'b0, 1'b0, "sb_wr",   {4'b0000, MWR | MB | IOD});

      // Branch family
      fetchDecode(6'b000100, 5'd0, 5'd0, "b");
      cyc(1'b0, 1'b0, 1'b0, "b_branch", {4'b1000, PCW | SA | PCS});
      fetchDecode(6'b000100, 5'd1, 5'd2, "beq_nt");
      cyc(1'b0, 1'b0, 1'b0, "beq_not_taken", {4'b0011, SA | PCS});
      fetchDecode(6'b000100, 5'd1, 5'd2, "beq_t");
      cyc(1'b0, 1'b1, 1'b0, "beq_taken", {4'b0011, PCW | SA | PCS});
      fetchDecode(6'b000111, 5'd9, 5'd0, "bgtz");
      cyc(1'b0, 1'b0, 1'b1, "bgtz_neg", {4'b0110, SA | PCS});
      fetchDecode(6'b000110, 5'd9, 5'd0, "blez");
      cyc(1'b0, 1'b0, 1'b1, "blez_neg", {4'b1001, PCW | SA | PCS});

      // Illegal opcode: TRAP after DECODE, sticky for 20 cycles
      fetchDecode(6'b111111, 5'd0, 5'd0, "ill");
      for (int i = 0; i < 20; i++)
         cyc(1'(i % 2), 1'b0, 1'b0, "ill_trap", TRAP_W);

      // Fetch timeout: 15 waiting cycles, then TRAP
      applyReset("rst_timeout");
      for (int i = 0; i < 15; i++)
         cyc(1'b0, 1'b0, 1'b0, "to_fetch_wait", FETCH_W);
      cyc(1'b0, 1'b0, 1'b0, "to_trap", TRAP_W);

      // mem_ready on the timeout cycle: completion wins
      applyReset("rst_race");
      opcode = 6'b000000;
      for (int i = 0; i < 14; i++)
         cyc(1'b0, 1'b0, 1'b0, "race_fetch_wait", FETCH_W);
      cyc(1'b1, 1'b0, 1'b0, "race_fetch_done", FETCH_R);
      cyc(1'b0, 1'b0, 1'b0, "race_decode", DECODE_W);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
